// File: rtl/perceptron_pkg.sv
// Shared definitions for the N-input perceptron.
//   - Q4.4 constants (ETA_1_0 = 1.0)
//   - FSM state encoding
//   - sat_add: saturating add clamped to a signed w-bit range
//   - 2-input truth-table targets (bit k = output for input combination k)
package perceptron_pkg;

  localparam int Q_FRAC  = 4;
  localparam int ETA_1_0 = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] TGT_AND  = 4'b1000;
  localparam logic [3:0] TGT_OR   = 4'b1110;
  localparam logic [3:0] TGT_NAND = 4'b0111;
  localparam logic [3:0] TGT_NOR  = 4'b0001;
  localparam logic [3:0] TGT_XOR  = 4'b0110;

  // a + b clamped to [-2^(w-1), 2^(w-1)-1]; operands are already sign-extended.
  function automatic int sat_add(input int a, input int b, input int w);
    int s, hi, lo;
    s  = a + b;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/perceptron_sum.sv
// Combinational neuron sum: s = b + sum of w[i] over every i with x[i] = 1.
// Ports:
//   x  - binary inputs
//   w  - N signed W-bit weights
//   b  - signed W-bit bias
//   s  - signed W+3-bit sum (wide enough that N <= 6 can never overflow)
module perceptron_sum #(
  parameter int N = 2,
  parameter int W = 8
) (
  input  logic [N-1:0]        x,
  input  logic [N-1:0][W-1:0] w,
  input  logic signed [W-1:0] b,
  output logic signed [W+2:0] s
);

  localparam int SW = W + 3;

  always_comb begin
    s = SW'(b);
    for (int i = 0; i < N; i++)
      if (x[i]) s = s + SW'($signed(w[i]));
  end

endmodule

// File: rtl/nary_perceptron.sv
// N-input single-layer perceptron with on-chip perceptron-rule training over
// the full 2^N truth table, saturating Q4.4 weights, and a registered predict
// path that runs in every state.
// Ports:
//   clk, aresetn               - clock, async active-low reset
//   x / y, sum_dbg             - predict inputs, registered prediction and sum
//   train_start, abort         - start pulse, stop training
//   targets, max_epochs, eta   - training job, latched on start
//   load_init, w_init, b_init  - initial weight load (ignored while training)
//   w_o, b_o                   - live weights / bias
//   busy, done, converged      - run status
//   epoch_count                - epochs completed in the current or last run
module nary_perceptron
  import perceptron_pkg::*;
#(
  parameter int N = 2,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic [N-1:0]         x,
  output logic                 y,
  output logic signed [W+2:0]  sum_dbg,
  input  logic                 train_start,
  input  logic                 abort,
  input  logic [(1<<N)-1:0]    targets,
  input  logic [15:0]          max_epochs,
  input  logic [W-1:0]         eta,
  input  logic                 load_init,
  input  logic [N*W-1:0]       w_init,
  input  logic [W-1:0]         b_init,
  output logic [N*W-1:0]       w_o,
  output logic [W-1:0]         b_o,
  output logic                 busy,
  output logic                 done,
  output logic                 converged,
  output logic [15:0]          epoch_count
);

  localparam int K = 1 << N;

  state_t                 state;
  logic [N-1:0][W-1:0]    w_q;
  logic signed [W-1:0]    b_q;
  logic [K-1:0]           tgt_q;
  logic signed [W-1:0]    eta_q;
  logic [15:0]            maxep_q;
  logic [N-1:0]           k_q;
  logic                   ep_err_q;

  logic signed [W+2:0]    s_pred, s_trn;
  logic                   t, pred_t, err_pos, err_neg, has_err, ep_err_all, at_limit;
  logic [N-1:0][W-1:0]    w_upd;
  logic signed [W-1:0]    b_upd;
  logic [15:0]            maxep_eff;

  assign w_o = w_q;
  assign b_o = b_q;

  perceptron_sum #(.N(N), .W(W)) u_pred (.x(x),   .w(w_q), .b(b_q), .s(s_pred));
  perceptron_sum #(.N(N), .W(W)) u_trn  (.x(k_q), .w(w_q), .b(b_q), .s(s_trn));

  // Training sample k: err = t - pred, so only the two mismatching cases update.
  assign t          = tgt_q[k_q];
  assign pred_t     = s_trn > 0;
  assign err_pos    = t & ~pred_t;
  assign err_neg    = ~t & pred_t;
  assign has_err    = err_pos | err_neg;
  assign ep_err_all = ep_err_q | has_err;
  assign maxep_eff  = (maxep_q == 16'd0) ? 16'd1 : maxep_q;
  // 17-bit compare so a 16-bit epoch_count wrap cannot defeat the limit.
  assign at_limit   = ({1'b0, epoch_count} + 17'd1) >= {1'b0, maxep_eff};

  always_comb begin
    int d;
    d     = err_pos ? int'(eta_q) : -int'(eta_q);
    b_upd = W'(sat_add(int'(b_q), d, W));
    for (int i = 0; i < N; i++)
      w_upd[i] = k_q[i] ? W'(sat_add(int'($signed(w_q[i])), d, W)) : w_q[i];
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= ST_IDLE;
      w_q         <= '0;
      b_q         <= '0;
      tgt_q       <= '0;
      eta_q       <= '0;
      maxep_q     <= '0;
      k_q         <= '0;
      ep_err_q    <= 1'b0;
      y           <= 1'b0;
      sum_dbg     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      converged   <= 1'b0;
      epoch_count <= '0;
    end else begin
      y       <= s_pred > 0;
      sum_dbg <= s_pred;
      case (state)
        ST_IDLE, ST_DONE: begin
          // Load first; a simultaneous start then trains from the loaded weights.
          if (load_init) begin
            w_q         <= w_init;
            b_q         <= b_init;
            done        <= 1'b0;
            converged   <= 1'b0;
            epoch_count <= '0;
            state       <= ST_IDLE;
          end
          if (train_start) begin
            tgt_q       <= targets;
            eta_q       <= eta;
            maxep_q     <= max_epochs;
            k_q         <= '0;
            ep_err_q    <= 1'b0;
            epoch_count <= '0;
            done        <= 1'b0;
            converged   <= 1'b0;
            busy        <= 1'b1;
            state       <= ST_TRAIN;
          end
        end
        ST_TRAIN: begin
          if (abort) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            converged <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            if (has_err) begin
              w_q <= w_upd;
              b_q <= b_upd;
            end
            k_q      <= k_q + N'(1);  // wraps to 0 at end of epoch
            ep_err_q <= ep_err_all;
            if (&k_q) begin
              epoch_count <= epoch_count + 16'd1;
              ep_err_q    <= 1'b0;
              if (!ep_err_all) begin
                converged <= 1'b1;
                done      <= 1'b1;
                busy      <= 1'b0;
                state     <= ST_DONE;
              end else if (at_limit) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= ST_DONE;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nary_perceptron.sv
module tb_nary_perceptron;
  import perceptron_pkg::*;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  logic        abort = 1'b0;
  logic [15:0] max_epochs = '0;
  logic [7:0]  eta = '0;

  // N=2 instance
  logic [1:0]  x2 = '0;
  logic        y2;
  logic signed [10:0] sum2;
  logic        start2 = 1'b0, load2 = 1'b0;
  logic [3:0]  tg2 = '0;
  logic [15:0] winit2 = '0;
  logic [7:0]  binit2 = '0;
  logic [15:0] wo2;
  logic [7:0]  bo2;
  logic        busy2, done2, conv2;
  logic [15:0] ep2;

  // N=3 instance
  logic [2:0]  x3 = '0;
  logic        y3;
  logic signed [10:0] sum3;
  logic        start3 = 1'b0, load3 = 1'b0;
  logic [7:0]  tg3 = '0;
  logic [23:0] winit3 = '0;
  logic [7:0]  binit3 = '0;
  logic [23:0] wo3;
  logic [7:0]  bo3;
  logic        busy3, done3, conv3;
  logic [15:0] ep3;

  nary_perceptron #(.N(2), .W(8)) dut2 (
    .clk(clk), .aresetn(aresetn), .x(x2), .y(y2), .sum_dbg(sum2),
    .train_start(start2), .abort(abort), .targets(tg2), .max_epochs(max_epochs),
    .eta(eta), .load_init(load2), .w_init(winit2), .b_init(binit2),
    .w_o(wo2), .b_o(bo2), .busy(busy2), .done(done2), .converged(conv2),
    .epoch_count(ep2));

  nary_perceptron #(.N(3), .W(8)) dut3 (
    .clk(clk), .aresetn(aresetn), .x(x3), .y(y3), .sum_dbg(sum3),
    .train_start(start3), .abort(abort), .targets(tg3), .max_epochs(max_epochs),
    .eta(eta), .load_init(load3), .w_init(winit3), .b_init(binit3),
    .w_o(wo3), .b_o(bo3), .busy(busy3), .done(done3), .converged(conv3),
    .epoch_count(ep3));

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state: weights and bias as plain integers.
  int mw[6];
  int mb;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp8(input int v);
    return (v > 127) ? 127 : ((v < -128) ? -128 : v);
  endfunction

  function automatic int msum(input int n, input int xv);
    int s = mb;
    for (int i = 0; i < n; i++) if (xv[i]) s += mw[i];
    return s;
  endfunction

  // Perceptron rule over the truth table, epoch by epoch. lim >= 0 stops the
  // model after that many samples (used to mirror an abort).
  function automatic void model_run(input int n, input logic [63:0] tg, input int e,
                                    input int mx, input int lim,
                                    output int ep, output bit cv, output int cyc);
    int me, err, pred;
    bit eerr;
    me  = (mx == 0) ? 1 : mx;
    ep  = 0;
    cv  = 0;
    cyc = 0;
    while (1) begin
      eerr = 0;
      for (int k = 0; k < (1 << n); k++) begin
        if (lim >= 0 && cyc == lim) return;
        pred = (msum(n, k) > 0) ? 1 : 0;
        err  = int'(tg[k]) - pred;
        if (err != 0) begin
          eerr = 1;
          mb = clamp8(mb + err * e);
          for (int i = 0; i < n; i++) if (k[i]) mw[i] = clamp8(mw[i] + err * e);
        end
        cyc++;
      end
      ep++;
      if (!eerr) begin cv = 1; return; end
      if (ep >= me) return;
    end
  endfunction

  task automatic load_w2(input int a0, input int a1, input int bb);
    winit2 = {8'(a1), 8'(a0)};
    binit2 = 8'(bb);
    load2 = 1'b1;
    tick();
    load2 = 1'b0;
    mw[0] = a0; mw[1] = a1; mb = bb;
  endtask

  task automatic start_2(input logic [3:0] tg, input int e, input int mx);
    tg2 = tg; eta = 8'(e); max_epochs = 16'(mx);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("busy_rise", busy2, 1);
    chk("done_clr", done2, 0);
  endtask

  task automatic check_w2(input string tag);
    chk({tag, "_w0"}, $signed(wo2[7:0]), mw[0]);
    chk({tag, "_w1"}, $signed(wo2[15:8]), mw[1]);
    chk({tag, "_b"}, $signed(bo2), mb);
  endtask

  task automatic finish2(input string tag, input logic [3:0] tg, input int e, input int mx,
                         output int ep, output bit cv, output int cyc);
    int c = 0;
    model_run(2, 64'(tg), e, mx, -1, ep, cv, cyc);
    while (!done2 && c < 4000) begin tick(); c++; end
    chk({tag, "_cycles"}, c, cyc);
    chk({tag, "_busy"}, busy2, 0);
    chk({tag, "_epochs"}, ep2, ep);
    chk({tag, "_conv"}, conv2, cv);
    check_w2(tag);
  endtask

  task automatic pred2(input string tag, input int xv);
    x2 = 2'(xv);
    tick();
    chk({tag, "_sum"}, sum2, msum(2, xv));
    chk({tag, "_y"}, y2, (msum(2, xv) > 0) ? 1 : 0);
  endtask

  initial begin
    int ep, cyc, c;
    bit cv;
    logic [3:0] rtg;
    int ra0, ra1, rb, re, rmx;

    repeat (2) tick();
    aresetn = 1'b1;
    tick();
    chk("rst_y", y2, 0);
    chk("rst_sum", sum2, 0);
    chk("rst_w", wo2, 0);
    chk("rst_b", bo2, 0);
    chk("rst_busy", busy2, 0);
    chk("rst_done", done2, 0);
    chk("rst_conv", conv2, 0);
    chk("rst_ep", ep2, 0);

    // AND from zero weights
    mw = '{default: 0}; mb = 0;
    start_2(TGT_AND, ETA_1_0, 100);
    finish2("and", TGT_AND, ETA_1_0, 100, ep, cv, cyc);
    chk("and_ep_const", ep2, 6);
    chk("and_w0_const", $signed(wo2[7:0]), 16);
    chk("and_w1_const", $signed(wo2[15:8]), 32);
    chk("and_b_const", $signed(bo2), -32);
    for (int k = 0; k < 4; k++) begin
      pred2("and_pred", k);
      chk("and_truth", y2, TGT_AND[k]);
    end

    // XOR never converges: runs to the epoch limit
    load_w2(0, 0, 0);
    start_2(TGT_XOR, ETA_1_0, 16);
    finish2("xor", TGT_XOR, ETA_1_0, 16, ep, cv, cyc);
    chk("xor_cyc_const", cyc, 64);
    chk("xor_ep_const", ep2, 16);
    chk("xor_done", done2, 1);

    // Saturation: w0 must clamp at 127 rather than wrap
    load_w2(120, -128, -128);
    start_2(4'b1111, ETA_1_0, 1);
    finish2("sat", 4'b1111, ETA_1_0, 1, ep, cv, cyc);
    chk("sat_w0_const", $signed(wo2[7:0]), 127);
    chk("sat_w1_const", $signed(wo2[15:8]), -96);
    chk("sat_b_const", $signed(bo2), -80);

    // Abort on the 3rd training cycle; sample k=2 would have updated
    load_w2(0, 0, 0);
    start_2(4'b1011, ETA_1_0, 10);
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    model_run(2, 64'(4'b1011), ETA_1_0, 10, 2, ep, cv, cyc);
    chk("abort_busy", busy2, 0);
    chk("abort_done", done2, 0);
    chk("abort_ep", ep2, 0);
    check_w2("abort_hold");
    tick();
    check_w2("abort_idle");
    start_2(4'b1011, ETA_1_0, 10);
    finish2("restart", 4'b1011, ETA_1_0, 10, ep, cv, cyc);

    // max_epochs = 0 acts as 1
    load_w2(0, 0, 0);
    start_2(TGT_XOR, ETA_1_0, 0);
    finish2("max0", TGT_XOR, ETA_1_0, 0, ep, cv, cyc);
    chk("max0_cyc_const", cyc, 4);
    chk("max0_ep_const", ep2, 1);

    // Randomized jobs; every other one loads and starts on the same edge
    for (int r = 0; r < 10; r++) begin
      ra0 = int'($urandom_range(0, 255)) - 128;
      ra1 = int'($urandom_range(0, 255)) - 128;
      rb  = int'($urandom_range(0, 255)) - 128;
      re  = int'($urandom_range(1, 48));
      rmx = int'($urandom_range(0, 12));
      rtg = 4'($urandom);
      if (r % 2 == 0) begin
        winit2 = {8'(ra1), 8'(ra0)}; binit2 = 8'(rb);
        tg2 = rtg; eta = 8'(re); max_epochs = 16'(rmx);
        load2 = 1'b1; start2 = 1'b1;
        tick();
        load2 = 1'b0; start2 = 1'b0;
        mw[0] = ra0; mw[1] = ra1; mb = rb;
        chk("rnd_busy", busy2, 1);
      end else begin
        load_w2(ra0, ra1, rb);
        start_2(rtg, re, rmx);
      end
      finish2("rnd", rtg, re, rmx, ep, cv, cyc);
      pred2("rnd_pred", int'($urandom_range(0, 3)));
      pred2("rnd_pred", int'($urandom_range(0, 3)));
    end

    // N=3 AND
    mw = '{default: 0}; mb = 0;
    tg3 = 8'h80; eta = 8'(ETA_1_0); max_epochs = 16'd50;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    model_run(3, 64'h80, ETA_1_0, 50, -1, ep, cv, cyc);
    c = 0;
    while (!done3 && c < 4000) begin tick(); c++; end
    chk("and3_cycles", c, cyc);
    chk("and3_conv", conv3, 1);
    chk("and3_ep", ep3, ep);
    for (int i = 0; i < 3; i++) chk("and3_w", $signed(wo3[i*8 +: 8]), mw[i]);
    chk("and3_b", $signed(bo3), mb);
    for (int k = 0; k < 8; k++) begin
      x3 = 3'(k);
      tick();
      chk("and3_truth", y3, (k == 7) ? 1 : 0);
      chk("and3_sum", sum3, msum(3, k));
    end

    // Async reset mid-run clears everything without a clock edge
    load3 = 1'b1; winit3 = 24'h102030; binit3 = 8'h05;
    tick();
    load3 = 1'b0;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    tick(); tick();
    chk("mid_busy", busy3, 1);
    #2 aresetn = 1'b0;
    #1;
    chk("arst_y", y3, 0);
    chk("arst_sum", sum3, 0);
    chk("arst_w", wo3, 0);
    chk("arst_b", bo3, 0);
    chk("arst_busy", busy3, 0);
    chk("arst_done", done3, 0);
    chk("arst_conv", conv3, 0);
    chk("arst_ep", ep3, 0);
    chk("arst_w2", wo2, 0);
    tick();
    aresetn = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
